// File: rtl/apb_sdcard_pkg.sv
// Shared definitions for the APB SD-card DMA control block.
// Holds register byte offsets, STATUS/CTRL bit indices, the sequencer state
// encoding and the descriptor layout pushed by a CMD write.
package apb_sdcard_pkg;

    // Descriptor field widths of the default configuration
    localparam int unsigned DESC_ADDR_W = 32;
    localparam int unsigned DESC_CNT_W  = 16;

    // Register byte offsets within the 4 KiB APB window
    localparam logic [11:0] OFF_CTRL     = 12'h000;
    localparam logic [11:0] OFF_ADDR     = 12'h004;
    localparam logic [11:0] OFF_COUNT    = 12'h008;
    localparam logic [11:0] OFF_CMD      = 12'h00C;
    localparam logic [11:0] OFF_STATUS   = 12'h010;
    localparam logic [11:0] OFF_CUR_ADDR = 12'h014;
    localparam logic [11:0] OFF_REMAIN   = 12'h018;

    // CTRL bit indices (the enable mask occupies the low RD_EN_W bits)
    localparam int unsigned CTRL_SRST_BIT  = 8;
    localparam int unsigned CTRL_IRQEN_BIT = 9;

    // STATUS bit indices
    localparam int unsigned ST_BUSY_BIT  = 0;
    localparam int unsigned ST_EMPTY_BIT = 1;
    localparam int unsigned ST_FULL_BIT  = 2;
    localparam int unsigned ST_DONE_BIT  = 3;
    localparam int unsigned ST_ERR_BIT   = 4;
    localparam int unsigned ST_OVF_BIT   = 5;
    localparam int unsigned ST_LVL_LSB   = 8;

    // Block-request sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Multi-block read descriptor
    typedef struct packed {
        logic [DESC_ADDR_W-1:0] addr;
        logic [DESC_CNT_W-1:0]  count;
    } desc_t;

endpackage

// File: rtl/apb_sdcard_dma_ctrl_fifo.sv
// sdcard_req_fifo: synchronous show-ahead FIFO for read descriptors.
// Ports: clk_i/rst_i (async active-high), flush_i empties the FIFO,
// push_i/wdata_i write (ignored when full), pop_i read (ignored when empty),
// rdata_o head entry, full_o/empty_o flags, level_o occupancy.
module sdcard_req_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push_c, do_pop_c;

    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign do_push_c = push_i & ~full_o & ~flush_i;
    assign do_pop_c  = pop_i & ~empty_o & ~flush_i;

    // Pointer/level next state; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push_c, do_pop_c})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array, no reset needed: entries are only read when valid
    always_ff @(posedge clk_i) begin
        if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/apb_sdcard_dma_ctrl.sv
// apb_sdcard_dma_ctrl: APB slave that queues multi-block SD read descriptors
// and issues them one block at a time over a valid/ready request interface.
// Ports: PCLK/PRESET (async active-high), APB slave (PSEL, PENABLE, PWRITE,
// PADDR, PWDATA, PRDATA, PREADY, PSLVERR), block request (sd_req_valid,
// sd_req_ready, sd_req_addr, sd_req_en), completion (sd_done, sd_err),
// reader soft reset sd_rst and level interrupt irq.
// Build option: define SDCARD_DMA_IRQ_EN to store CTRL.irq_en and drive irq;
// otherwise irq is tied 0 and CTRL[9] reads 0.
// Descriptors pass through the packaged desc_t layout, so ADDR_W and CNT_W
// are carried at most DESC_ADDR_W / DESC_CNT_W bits wide.
module apb_sdcard_dma_ctrl
    import apb_sdcard_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RD_EN_W    = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [11:2]        PADDR,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    output logic               sd_req_valid,
    input  logic               sd_req_ready,
    output logic [ADDR_W-1:0]  sd_req_addr,
    output logic [RD_EN_W-1:0] sd_req_en,
    input  logic               sd_done,
    input  logic               sd_err,
    output logic               sd_rst,
    output logic               irq
);

    localparam int unsigned FIFO_W = ADDR_W + CNT_W;
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;

    // APB decode
    logic [11:0] byte_addr_c;
    logic        wr_c, wr_ctrl_c, wr_addr_c, wr_count_c, wr_cmd_c, wr_status_c;
    logic        push_c, cmd_rej_c;

    // Configuration and status registers
    logic [RD_EN_W-1:0] ctrl_en_q, ctrl_en_d;
    logic               ctrl_srst_q, ctrl_srst_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               st_done_q, st_done_d;
    logic               st_err_q, st_err_d;
    logic               st_ovf_q, st_ovf_d;
    logic               irq_en_rd_c;

    // Sequencer
    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic               req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic               pop_c, set_done_c, set_err_c;

    // FIFO
    desc_t              push_desc_c;
    logic [FIFO_W-1:0]  fifo_wdata_c, fifo_rdata_c;
    logic [ADDR_W-1:0]  fifo_addr_c;
    logic [CNT_W-1:0]   fifo_cnt_c;
    logic               fifo_full_c, fifo_empty_c;
    logic [LVL_W-1:0]   fifo_level_c;

    assign byte_addr_c = {PADDR, 2'b00};
    assign wr_c        = PSEL & PENABLE & PWRITE;
    assign wr_ctrl_c   = wr_c & (byte_addr_c == OFF_CTRL);
    assign wr_addr_c   = wr_c & (byte_addr_c == OFF_ADDR);
    assign wr_count_c  = wr_c & (byte_addr_c == OFF_COUNT);
    assign wr_cmd_c    = wr_c & (byte_addr_c == OFF_CMD);
    assign wr_status_c = wr_c & (byte_addr_c == OFF_STATUS);

    // A full FIFO or an asserted soft reset rejects the push with an error response
    assign cmd_rej_c   = wr_cmd_c & (fifo_full_c | ctrl_srst_q);
    assign push_c      = wr_cmd_c & ~fifo_full_c & ~ctrl_srst_q;

    assign PREADY       = 1'b1;
    assign PSLVERR      = cmd_rej_c;
    assign sd_req_valid = req_valid_q;
    assign sd_req_addr  = req_addr_q;
    assign sd_req_en    = ctrl_en_q;
    assign sd_rst       = ctrl_srst_q;

    // Descriptor assembly from the staged ADDR/COUNT registers
    always_comb begin
        push_desc_c.addr  = DESC_ADDR_W'(addr_q);
        push_desc_c.count = DESC_CNT_W'(count_q);
        fifo_wdata_c      = {ADDR_W'(push_desc_c.addr), CNT_W'(push_desc_c.count)};
    end

    assign fifo_addr_c = fifo_rdata_c[FIFO_W-1 -: ADDR_W];
    assign fifo_cnt_c  = fifo_rdata_c[CNT_W-1:0];

    sdcard_req_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .flush_i (ctrl_srst_q),
        .push_i  (push_c),
        .wdata_i (fifo_wdata_c),
        .pop_i   (pop_c),
        .rdata_o (fifo_rdata_c),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c),
        .level_o (fifo_level_c)
    );

    // Register write and sticky status update; a set in the same cycle beats W1C
    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        ctrl_srst_d = ctrl_srst_q;
        addr_d      = addr_q;
        count_d     = count_q;
        if (wr_ctrl_c) begin
            ctrl_en_d   = PWDATA[RD_EN_W-1:0];
            ctrl_srst_d = PWDATA[CTRL_SRST_BIT];
        end
        if (wr_addr_c)  addr_d  = ADDR_W'(PWDATA);
        if (wr_count_c) count_d = CNT_W'(PWDATA);
        st_done_d = set_done_c | (st_done_q & ~(wr_status_c & PWDATA[ST_DONE_BIT]));
        st_err_d  = set_err_c  | (st_err_q  & ~(wr_status_c & PWDATA[ST_ERR_BIT]));
        st_ovf_d  = cmd_rej_c  | (st_ovf_q  & ~(wr_status_c & PWDATA[ST_OVF_BIT]));
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_en_q   <= '0;
            ctrl_srst_q <= 1'b0;
            addr_q      <= '0;
            count_q     <= '0;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
            st_ovf_q    <= 1'b0;
            cur_addr_q  <= '0;
            remain_q    <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
        end else begin
            ctrl_en_q   <= ctrl_en_d;
            ctrl_srst_q <= ctrl_srst_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            st_done_q   <= st_done_d;
            st_err_q    <= st_err_d;
            st_ovf_q    <= st_ovf_d;
            cur_addr_q  <= cur_addr_d;
            remain_q    <= remain_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
        end
    end

`ifdef SDCARD_DMA_IRQ_EN
    logic irq_en_q, irq_en_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl_c) irq_en_d = PWDATA[CTRL_IRQEN_BIT];
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) irq_en_q <= 1'b0;
        else        irq_en_q <= irq_en_d;
    end

    assign irq_en_rd_c = irq_en_q;
    assign irq         = irq_en_q & (st_done_q | st_err_q | st_ovf_q);
`else
    assign irq_en_rd_c = 1'b0;
    assign irq         = 1'b0;
`endif

    // Sequencer state register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Sequencer next state; soft reset parks it in IDLE
    always_comb begin
        state_d = state_q;
        if (ctrl_srst_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (!fifo_empty_c) state_d = (fifo_cnt_c == '0) ? ST_IDLE : ST_ISSUE;
                ST_ISSUE: if (req_valid_q && sd_req_ready) state_d = ST_WAIT;
                ST_WAIT: begin
                    if (sd_done) begin
                        if (sd_err || remain_q == CNT_W'(1)) state_d = ST_IDLE;
                        else                                 state_d = ST_ISSUE;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer outputs: pop, descriptor progress, request valid/address, status sets.
    // The request is registered, so valid rises one cycle after entering ISSUE
    // and falls on the handshake edge.
    always_comb begin
        pop_c       = 1'b0;
        set_done_c  = 1'b0;
        set_err_c   = 1'b0;
        cur_addr_d  = cur_addr_q;
        remain_d    = remain_q;
        req_valid_d = 1'b0;
        req_addr_d  = req_addr_q;
        if (!ctrl_srst_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_c) begin
                        pop_c      = 1'b1;
                        cur_addr_d = fifo_addr_c;
                        remain_d   = fifo_cnt_c;
                        set_done_c = (fifo_cnt_c == '0);
                    end
                end
                ST_ISSUE: begin
                    req_addr_d  = cur_addr_q;
                    req_valid_d = ~(req_valid_q & sd_req_ready);
                end
                ST_WAIT: begin
                    if (sd_done) begin
                        if (sd_err) begin
                            set_err_c = 1'b1;
                        end else begin
                            cur_addr_d = cur_addr_q + ADDR_W'(1);
                            remain_d   = remain_q - CNT_W'(1);
                            set_done_c = (remain_q == CNT_W'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Zero-wait read mux; PRDATA is 0 outside a read select
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (byte_addr_c)
                OFF_CTRL: begin
                    PRDATA[7:0]            = 8'(ctrl_en_q);
                    PRDATA[CTRL_SRST_BIT]  = ctrl_srst_q;
                    PRDATA[CTRL_IRQEN_BIT] = irq_en_rd_c;
                end
                OFF_ADDR:     PRDATA = 32'(addr_q);
                OFF_COUNT:    PRDATA = 32'(count_q);
                OFF_STATUS: begin
                    PRDATA[ST_BUSY_BIT]               = (state_q != ST_IDLE);
                    PRDATA[ST_EMPTY_BIT]              = fifo_empty_c;
                    PRDATA[ST_FULL_BIT]               = fifo_full_c;
                    PRDATA[ST_DONE_BIT]               = st_done_q;
                    PRDATA[ST_ERR_BIT]                = st_err_q;
                    PRDATA[ST_OVF_BIT]                = st_ovf_q;
                    PRDATA[ST_LVL_LSB +: 8]           = 8'(fifo_level_c);
                end
                OFF_CUR_ADDR: PRDATA = 32'(cur_addr_q);
                OFF_REMAIN:   PRDATA = 32'(remain_q);
                default:      PRDATA = '0;
            endcase
        end
    end

endmodule
